// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (start, DATA_W data LSB first, parity, stop) with a one-deep output slot.
// Define PARITY_FRAME_RX_ERRCNT_EN to add cnt_clr/err_cnt, a saturating count of frames loaded with an error.
module parity_frame_rx #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  input  logic              cnt_clr,
  output logic [7:0]        err_cnt,
`endif
  input  logic              rx_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              overrun
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift, r_data;
  logic              r_acc, r_perr, r_valid, r_par, r_frm, r_ovr;
  logic              w_last, w_done, w_free, w_load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = !bit_en           ? r_state :
             r_state == IDLE   ? (rx_in ? IDLE : DATA) :
             r_state == DATA   ? (w_last ? PAR : DATA) :
             r_state == PAR    ? STOP : IDLE;
  // Slot is free if empty or being drained on this same edge.
  always_comb begin
    w_last = r_cnt == CW'(DATA_W - 1);
    w_done = bit_en && r_state == STOP;
    w_free = !r_valid || m_ready;
    w_load = w_done && w_free;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_frm   <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bit_en && r_state == IDLE && !rx_in) begin
        r_cnt <= '0;
        r_acc <= 1'b0;
      end
      if (bit_en && r_state == DATA) begin
        r_shift <= DATA_W'({rx_in, r_shift} >> 1);
        r_acc   <= r_acc ^ rx_in;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (bit_en && r_state == PAR) r_perr <= (r_acc ^ rx_in) != ODD;
      if (w_load) begin
        r_data <= r_shift;
        r_par  <= r_perr;
        r_frm  <= !rx_in;
      end
      r_valid <= w_load || (r_valid && !m_ready);
      r_ovr   <= w_done && !w_free;
    end
  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign par_err = r_par;
  assign frm_err = r_frm;
  assign overrun = r_ovr;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err_cnt <= '0;
    else if (cnt_clr) r_err_cnt <= '0;
    else if (w_load && (r_perr || !rx_in) && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  assign err_cnt = r_err_cnt;
`else
`endif
endmodule
